// File: rtl/bist_pkg.sv
// Shared definitions for the BIST session controller: state encoding and default sizing.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned DEF_SIG_W    = 8;
  localparam int unsigned DEF_PAT_CNT  = 14;
  localparam int unsigned DEF_SESSIONS = 4;

  localparam int unsigned PAT_CNT_W  = 8;
  localparam int unsigned SESS_IDX_W = 4;

endpackage

// File: rtl/bist_pat_counter.sv
// Pattern-window counter: synchronous clear, load, up/down count and a terminal-count flag
// that is high while the count equals i_tc_val.
module bist_pat_counter
  import bist_pkg::*;
#(
  parameter int unsigned W = PAT_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: reset beats load, load beats count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_up ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/bist_session_ctrl.sv
// BIST session controller: sequences clear / pattern window / capture for a fixed number of
// sessions, compares the MISR signature per session and reports a pass/fail mask.
module bist_session_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned SIG_W    = DEF_SIG_W,
  parameter int unsigned PAT_CNT  = DEF_PAT_CNT,
  parameter int unsigned SESSIONS = DEF_SESSIONS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [SIG_W-1:0]      SIG_IN,
  input  logic [SIG_W-1:0]      GOLDEN,
  output logic                  SE,
  output logic                  MISR_CLR,
  output logic [SESS_IDX_W-1:0] SESS_IDX,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [SESSIONS-1:0]   FAIL_MASK
);

  state_t                  r_state;
  state_t                  w_state_d;
  logic [SESS_IDX_W-1:0]   r_sess_idx;
  logic [SESS_IDX_W-1:0]   w_sess_idx_d;
  logic [SESSIONS-1:0]     r_fail_mask;
  logic [SESSIONS-1:0]     w_fail_mask_d;
  logic                    w_pat_tc;
  logic                    w_last_sess;

  logic r_se, r_misr_clr, r_busy, r_done, r_pass;
  logic w_se_d, w_misr_clr_d, w_busy_d, w_done_d, w_pass_d;

  assign w_last_sess = (r_sess_idx == SESS_IDX_W'(SESSIONS - 1));

  // The window count is zeroed during CLEAR so the first RUN cycle sees 0.
  bist_pat_counter #(
    .W(PAT_CNT_W)
  ) u_pat_counter (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (r_state == ST_CLEAR),
    .i_load_val ('0),
    .i_en       (r_state == ST_RUN),
    .i_up       (1'b1),
    .i_tc_val   (PAT_CNT_W'(PAT_CNT - 1)),
    .o_tc       (w_pat_tc)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE:    if (START) w_state_d = ST_CLEAR;
      ST_CLEAR:   w_state_d = ST_RUN;
      ST_RUN:     if (w_pat_tc) w_state_d = ST_CAPTURE;
      ST_CAPTURE: w_state_d = w_last_sess ? ST_DONE : ST_CLEAR;
      ST_DONE:    if (START) w_state_d = ST_CLEAR;
      default:    w_state_d = ST_IDLE;
    endcase
  end

  // Session index and fail mask: cleared on (re)start, updated at the end of CAPTURE.
  always_comb begin
    w_sess_idx_d  = r_sess_idx;
    w_fail_mask_d = r_fail_mask;
    unique case (r_state)
      ST_IDLE: begin
        w_sess_idx_d  = '0;
        w_fail_mask_d = '0;
      end
      ST_DONE: begin
        if (START) begin
          w_sess_idx_d  = '0;
          w_fail_mask_d = '0;
        end
      end
      ST_CAPTURE: begin
        // Written as if/else so an X compare lands in the mismatch branch.
        if (SIG_IN == GOLDEN) begin
          w_fail_mask_d = r_fail_mask;
        end else begin
          for (int unsigned i = 0; i < SESSIONS; i++) begin
            if (r_sess_idx == SESS_IDX_W'(i)) w_fail_mask_d[i] = 1'b1;
          end
        end
        if (!w_last_sess) w_sess_idx_d = r_sess_idx + 1'b1;
      end
      default: ;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    w_se_d       = (w_state_d == ST_RUN);
    w_misr_clr_d = (w_state_d == ST_CLEAR);
    w_busy_d     = (w_state_d == ST_CLEAR) || (w_state_d == ST_RUN) ||
                   (w_state_d == ST_CAPTURE);
    w_done_d     = (w_state_d == ST_DONE);
    w_pass_d     = (w_state_d == ST_DONE) && (w_fail_mask_d == '0);
  end

  // Output and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_se        <= 1'b0;
      r_misr_clr  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_sess_idx  <= '0;
      r_fail_mask <= '0;
    end else begin
      r_se        <= w_se_d;
      r_misr_clr  <= w_misr_clr_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_pass      <= w_pass_d;
      r_sess_idx  <= w_sess_idx_d;
      r_fail_mask <= w_fail_mask_d;
    end
  end

  assign SE        = r_se;
  assign MISR_CLR  = r_misr_clr;
  assign SESS_IDX  = r_sess_idx;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign FAIL_MASK = r_fail_mask;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Bench for bist_session_ctrl: a timeline model (offset since the accepted START) predicts
// every output each cycle, plus literal checks on run length, pulse counts and masks.
module tb_bist_session_ctrl;

  localparam int unsigned SIG_W    = 8;
  localparam int unsigned PAT_CNT  = 14;
  localparam int unsigned SESSIONS = 4;
  localparam int L   = PAT_CNT + 2;
  localparam int TOT = SESSIONS * L;

  logic                CLK = 1'b0;
  logic                RST;
  logic                START;
  logic [SIG_W-1:0]    SIG_IN;
  logic [SIG_W-1:0]    GOLDEN;
  logic                SE;
  logic                MISR_CLR;
  logic [3:0]          SESS_IDX;
  logic                BUSY;
  logic                DONE;
  logic                PASS;
  logic [SESSIONS-1:0] FAIL_MASK;

  bist_session_ctrl #(
    .SIG_W   (SIG_W),
    .PAT_CNT (PAT_CNT),
    .SESSIONS(SESSIONS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .SIG_IN   (SIG_IN),
    .GOLDEN   (GOLDEN),
    .SE       (SE),
    .MISR_CLR (MISR_CLR),
    .SESS_IDX (SESS_IDX),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .FAIL_MASK(FAIL_MASK)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  // Model: m_off = cycles since the accepted START edge (-1 idle, TOT = done).
  int m_off    = -1;
  int m_mask   = 0;
  int bad_sess = -1;

  function automatic bit m_busy();
    return (m_off >= 0) && (m_off < TOT);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_update();
    if (RST) begin
      m_off  = -1;
      m_mask = 0;
    end else if (START && !m_busy()) begin
      m_off  = 0;
      m_mask = 0;
    end else if (m_busy()) begin
      if ((m_off % L == L - 1) && (SIG_IN !== GOLDEN)) m_mask = m_mask | (1 << (m_off / L));
      m_off++;
    end
  endtask

  task automatic check_outputs();
    int  p;
    bit  busy;
    bit  done;
    int  idx;
    p    = m_off % L;
    busy = m_busy();
    done = (m_off >= TOT);
    idx  = busy ? (m_off / L) : (done ? SESSIONS - 1 : 0);
    chk("se",       32'(SE),        32'(busy && p >= 1 && p <= PAT_CNT));
    chk("misr_clr", 32'(MISR_CLR),  32'(busy && p == 0));
    chk("busy",     32'(BUSY),      32'(busy));
    chk("done",     32'(DONE),      32'(done));
    chk("pass",     32'(PASS),      32'(done && m_mask == 0));
    chk("sess_idx", 32'(SESS_IDX),  32'(idx));
    chk("mask",     32'(FAIL_MASK), 32'(m_mask));
  endtask

  task automatic tick();
    GOLDEN = (m_busy() && (m_off / L == bad_sess)) ? 8'h00 : 8'hA5;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check_outputs();
  endtask

  // One run from a START pulse; returns the observation index where DONE first appears.
  task automatic run(input bit extra, input int rst_at, output int done_k, output int se_cnt,
                     output int clr_cnt, output int mask0);
    done_k  = -1;
    se_cnt  = 0;
    clr_cnt = 0;
    START   = 1'b1;
    tick();
    START   = 1'b0;
    mask0   = int'(FAIL_MASK);
    for (int k = 0; k < 100; k++) begin
      if (SE === 1'b1) se_cnt++;
      if (MISR_CLR === 1'b1) clr_cnt++;
      if (DONE === 1'b1) begin
        done_k = k;
        break;
      end
      START = extra && (k == L + 3 || k == L + 9);
      if (k == rst_at) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        break;
      end
      tick();
    end
    START = 1'b0;
  endtask

  int dk, se_n, clr_n, m0;

  initial begin
    RST    = 1'b1;
    START  = 1'b0;
    SIG_IN = 8'hA5;
    GOLDEN = 8'hA5;
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("idle_done", 32'(DONE), 32'd0);
    chk("idle_se",   32'(SE),   32'd0);

    // Clean run from IDLE.
    bad_sess = -1;
    run(1'b0, -1, dk, se_n, clr_n, m0);
    chk("clean_done_cyc", 32'(dk), 32'd64);
    chk("clean_se_cnt",   32'(se_n), 32'd56);
    chk("clean_clr_cnt",  32'(clr_n), 32'd4);
    chk("clean_pass",     32'(PASS), 32'd1);
    chk("clean_mask",     32'(FAIL_MASK), 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // Session 2 mismatches, restarted from DONE.
    bad_sess = 2;
    run(1'b0, -1, dk, se_n, clr_n, m0);
    chk("bad2_done_cyc", 32'(dk), 32'd64);
    chk("bad2_mask",     32'(FAIL_MASK), 32'h4);
    chk("bad2_pass",     32'(PASS), 32'd0);
    tick();

    // Restart from a failing DONE clears the mask at the restart edge.
    bad_sess = -1;
    run(1'b0, -1, dk, se_n, clr_n, m0);
    chk("restart_mask0", 32'(m0), 32'd0);
    chk("restart_pass",  32'(PASS), 32'd1);

    // Extra STARTs during session 1 RUN are ignored.
    run(1'b1, -1, dk, se_n, clr_n, m0);
    chk("extra_done_cyc", 32'(dk), 32'd64);
    chk("extra_se_cnt",   32'(se_n), 32'd56);
    chk("extra_clr_cnt",  32'(clr_n), 32'd4);

    // Reset on the 7th SE-high cycle of session 1.
    run(1'b0, L + 7, dk, se_n, clr_n, m0);
    chk("rst_se_cnt", 32'(se_n), 32'd21);
    chk("rst_se",     32'(SE), 32'd0);
    chk("rst_busy",   32'(BUSY), 32'd0);
    chk("rst_idx",    32'(SESS_IDX), 32'd0);
    run(1'b0, -1, dk, se_n, clr_n, m0);
    chk("post_rst_done_cyc", 32'(dk), 32'd64);
    chk("post_rst_se_cnt",   32'(se_n), 32'd56);
    chk("post_rst_pass",     32'(PASS), 32'd1);

    // RST and START together: reset wins, stays IDLE.
    RST   = 1'b1;
    START = 1'b1;
    tick();
    RST   = 1'b0;
    START = 1'b0;
    tick();
    chk("rst_start_clr",  32'(MISR_CLR), 32'd0);
    chk("rst_start_busy", 32'(BUSY), 32'd0);
    chk("rst_start_done", 32'(DONE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
